// File: rtl/uart_frame_streamer.sv
// Serialises a DATA_WIDTH-bit snapshot as a burst of 8N1/8N2 UART bytes with a start/busy/done handshake.
// Optional build macro UART_FRAME_CHECKSUM_EN appends a modulo-256 sum byte after the payload.
module uart_frame_streamer #(
  parameter int DATA_WIDTH         = 1072,
  parameter int UART_TICKS_PER_BIT = 139,
  parameter int GAP_TICKS          = 727273,
  parameter bit MSB_BYTE_FIRST     = 1'b0,
  parameter int STOP_BITS          = 1,
  localparam int NUM_BYTES         = DATA_WIDTH / 8,
  localparam int IDX_W             = $clog2(NUM_BYTES + 1)
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  input  logic                  repeat_en,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      byte_index,
  output logic                  tx_out
);

  localparam int TICK_W = $clog2(UART_TICKS_PER_BIT);
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UART_TICKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0]  LAST_POS  = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT, GAP} state_e;

  state_e                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [2:0]            bit_q, bit_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [7:0]            shift_q, shift_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick_end, load_frame, load_next, more_bytes;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  assign more_bytes = (idx_q < IDX_W'(NUM_BYTES));
`else
  assign more_bytes = (idx_q < LAST_POS);
`endif

  // The shadow register is consumed as a shift register so the next byte is always at one end.
  function automatic logic [7:0] head_byte(input logic [DATA_WIDTH-1:0] v);
    if (MSB_BYTE_FIRST) return v[DATA_WIDTH-1 -: 8];
    else                return v[7:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
    if (MSB_BYTE_FIRST) return v << 8;
    else                return v >> 8;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    shadow_d   = shadow_q;
    done_d     = 1'b0;
    load_frame = 1'b0;
    load_next  = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    tick_end   = (tick_q == TICK_LAST);

    case (state_q)
      IDLE: load_frame = start;
      START: begin
        if (tick_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else tick_d = tick_q + TICK_W'(1);
      end
      DATA: begin
        if (tick_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else bit_d = bit_q + 3'd1;
        end else tick_d = tick_q + TICK_W'(1);
      end
      STOP: begin
        if (tick_end) begin
          tick_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = NEXT;
          end else bit_d = bit_q + 3'd1;
        end else tick_d = tick_q + TICK_W'(1);
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (repeat_en) load_frame = 1'b1;
          else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // NEXT is resolved on the same edge the last stop period expires; it is never occupied.
    if (state_d == NEXT) begin
      if (more_bytes) load_next = 1'b1;
      else if (repeat_en) begin
        state_d = GAP;
        gap_d   = '0;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (load_frame) begin
      shift_d  = head_byte(data_in);
      shadow_d = advance(data_in);
      idx_d    = '0;
      tick_d   = '0;
      state_d  = START;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_d    = head_byte(data_in);
`endif
    end

    if (load_next) begin
      shadow_d = advance(shadow_q);
      idx_d    = idx_q + IDX_W'(1);
      tick_d   = '0;
      state_d  = START;
`ifdef UART_FRAME_CHECKSUM_EN
      if (idx_q == LAST_POS) shift_d = sum_q;
      else begin
        shift_d = head_byte(shadow_q);
        sum_d   = sum_q + head_byte(shadow_q);
      end
`else
      shift_d  = head_byte(shadow_q);
`endif
    end

    if (state_d == IDLE) idx_d = '0;

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // NOTE: the wide shadow register is pure datapath, always written at frame load, so it has no reset.
  always_ff @(posedge clk_in) begin
    shadow_q <= shadow_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign byte_index = idx_q;
  assign tx_out     = tx_q;

endmodule

// File: doc/uart_frame_streamer.md
Name: uart_frame_streamer

Overview:
- Parametrised successor to the debugger-as-transmitter stimulus path: serialises a DATA_WIDTH-bit snapshot as 8N1/8N2 UART bytes.
- Used as a bench and bring-up source feeding control_module's uart_rx.
- Generalised over the fixed-size debugger: selectable byte order, stop-bit count, one-shot or repeating frames with a programmable gap, and a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 1072: payload bits; must be a multiple of 8 and at least 8. NUM_BYTES = DATA_WIDTH/8.
- UART_TICKS_PER_BIT, 139: clk_in cycles per UART bit; must be at least 2.
- GAP_TICKS, 727273: idle-high cycles between repeated frames; must be at least 1.
- MSB_BYTE_FIRST, 0:
  - 0 sends byte 0 (data_in[7:0]) first.
  - 1 sends byte NUM_BYTES-1 first, so a string literal goes out in reading order.
- STOP_BITS, 1: 1 or 2 stop bits per byte.

Ports:
- clk_in  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  payload; sampled only at frame load.
- start  input  1  request one frame; sampled when idle.
- repeat_en  input  1  when high, keep re-sending frames separated by GAP_TICKS.
- busy  output  1  high from load until return to IDLE.
- done  output  1  one-cycle pulse when the streamer returns to IDLE.
- byte_index  output  $clog2(NUM_BYTES+1)  index of the byte position currently on the line.
- tx_out  output  1  UART line, idle high.

Behaviour:
- Reset (asynchronous assert, synchronous release): tx_out=1, busy=0, done=0, byte_index=0, state IDLE, all counters 0. Reset mid-frame drives tx_out high immediately and abandons the frame with no done pulse.
- States: IDLE, START, DATA, STOP, NEXT, GAP.
- IDLE:
  - start=1 on edge N: data_in is latched into a shadow register; busy=1 at N+1.
  - tx_out goes low (START) at N+1.
  - start while busy is ignored and not queued.
- START, DATA and STOP each hold every bit for exactly UART_TICKS_PER_BIT cycles, using a tick counter of width $clog2(UART_TICKS_PER_BIT).
- DATA sends 8 bits, LSB first. STOP drives 1 for STOP_BITS bit periods.
- NEXT takes zero extra cycles.
  - If more bytes remain: byte_index increments and the FSM enters START on the same edge the last stop period expires.
  - Otherwise the frame is over.
- byte_index counts transmission positions, 0..NUM_BYTES-1, in sending order, not the byte's address. It becomes NUM_BYTES during a checksum trailer, if present.
- Frame length: NUM_BYTES*(9+STOP_BITS)*UART_TICKS_PER_BIT cycles, with no inter-byte idle.
- End of frame, repeat_en=0: return to IDLE; busy=0 and done=1 for one cycle on the same edge.
- End of frame, repeat_en=1: enter GAP with tx_out=1 for GAP_TICKS cycles. At gap end, repeat_en is re-sampled:
  - If 1: re-latch data_in and enter START.
  - If 0: go to IDLE with a done pulse.
- Each repeated frame does not pulse done; done fires only on the final return to IDLE.
- start arriving during GAP is ignored.
- data_in changes while busy do not affect the frame in flight.

Optional Feature:
- Macro: UART_FRAME_CHECKSUM_EN.
- When defined: after the last payload byte, one extra byte is sent, framed like the payload bytes.
  - Value: the 8-bit modulo-256 sum of all payload bytes, accumulated as each byte is loaded.
  - byte_index = NUM_BYTES during the trailer.
  - Frame length grows by one byte time.
- When undefined: no trailer, no accumulator logic, and byte_index never exceeds NUM_BYTES-1.

Test Plan:
1. DATA_WIDTH=16, TICKS=4, MSB_BYTE_FIRST=0, data_in=16'hA55A, start pulse at cycle 10:
   - tx_out low during cycles 11-14.
   - Then bits 0,1,0,1,1,0,1,0 (0x5A), stop, then 0xA5.
   - busy falls and done pulses at cycle 91 (80-cycle frame).
2. Same stimulus with MSB_BYTE_FIRST=1 -> 0xA5 is decoded first, then 0x5A; byte_index is 0 then 1.
3. STOP_BITS=2, DATA_WIDTH=8, data_in=8'h00 -> start bit, 8 zero bits, then 8 high cycles; 44-cycle frame; done at cycle 45 after the load edge.
4. repeat_en=1, GAP_TICKS=7; change data_in to 16'h1234 during the first frame:
   - First frame still sends 5A,A5.
   - Line stays high for 7 cycles.
   - Second frame sends 34,12.
   - Drop repeat_en during the second frame -> single done pulse after it.
5. Assert reset low mid-DATA of byte 1 -> tx_out=1 in the same cycle, busy=0, no done pulse. A new start after release sends a complete fresh frame.
6. With UART_FRAME_CHECKSUM_EN, data_in=16'hA55A -> trailer byte 0xFF with byte_index=2; frame is 120 cycles. With data 16'h0102 -> trailer 0x03.
